pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, 16, program counter width in bits.
REQ-002 Parameter BR_IMM_W, 6, branch offset width (two's complement, instruction-word units).
REQ-003 Parameter J_IMM_W, 12, jump offset width (two's complement, instruction-word units).
REQ-004 Parameter STACK_DEPTH, 4, return-address stack entries (power of two, >=2).
REQ-005 Parameter INT_VECTOR, 16'h0010, PC loaded on interrupt entry (truncated to PC_W).
REQ-006 One clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 clk_en  in  1  advance enable; when low, all state holds.
REQ-010 branch_taken  in  1  conditional branch resolved taken.
REQ-011 branch_immediate  in  BR_IMM_W  branch offset.
REQ-012 jump_taken  in  1  unconditional jump.
REQ-013 jump_link  in  1  with jump_taken: push return address (JL).
REQ-014 jump_immediate  in  J_IMM_W  jump offset.
REQ-015 return_cmd  in  1  pop return address into PC.
REQ-016 halt_cmd  in  1  enter HALTED.
REQ-017 int_enable_cmd / int_disable_cmd  in  1 each  set/clear interrupt enable.
REQ-018 int_req  in  1  level interrupt request.
REQ-019 pc  out  PC_W  current instruction address.
REQ-020 halted  out  1  high in HALTED state.
REQ-021 int_active  out  1  inside interrupt handler.
REQ-022 int_en  out  1  interrupt enable flag.
REQ-023 stack_count  out  clog2(STACK_DEPTH)+1  occupied entries.
REQ-024 stack_overflow / stack_underflow  out  1 each  sticky error flags.

Function
REQ-025 States RUN and HALTED; all updates occur only on clk rising edge with clk_en=1.
REQ-026 seq = pc+2; offsets are sign-extended to PC_W, shifted left 1, added to seq; all arithmetic is modulo 2^PC_W.
REQ-027 RUN priority, highest first: interrupt entry, return_cmd, jump_taken, branch_taken, halt_cmd, sequential.
REQ-028 Interrupt entry when int_req & int_en & ~int_active: push seq, pc<=INT_VECTOR, int_active<=1, int_en<=0; other commands that cycle are ignored.
REQ-029 return_cmd: pc<=top, pop; if int_active then int_active<=0, int_en<=1.
REQ-030 jump_taken: pc<=seq+(sext(jump_immediate)<<1); if jump_link, push seq.
REQ-031 branch_taken: pc<=seq+(sext(branch_immediate)<<1).
REQ-032 halt_cmd: pc holds, state<=HALTED.
REQ-033 HALTED: pc holds; an interrupt entry (REQ-028 condition) returns to RUN, pushing pc+2; all other commands ignored.
REQ-034 Push when stack_count==STACK_DEPTH: push dropped, stack unchanged, stack_overflow<=1, PC change still performed.
REQ-035 Pop when stack_count==0: pc<=seq, stack_underflow<=1, int_active/int_en unchanged.
REQ-036 int_enable_cmd/int_disable_cmd apply in RUN when not overridden by interrupt entry; disable wins if both are asserted.
REQ-037 Stack is LIFO; pushes and pops never coincide in one cycle.

Reset
REQ-038 reset (sampled regardless of clk_en) sets pc=0, state=RUN, int_en=0, int_active=0, stack_count=0, both sticky flags=0; stack contents are don't-care.
REQ-039 reset overrides every simultaneous command, including mid-handler.

Structure
REQ-040 State encoding and default constants (INT_VECTOR, instruction size 2) reside in shared package pc_seq_pkg.
REQ-041 Return stack is sub-module pc_return_stack (push, pop, top, count, full, empty).

Verification
REQ-042 reset, 3 cycles clk_en=1 -> pc 0,2,4,6.
REQ-043 pc=0x0010, branch_taken, branch_immediate=6'b111110 -> pc=0x000E; clk_en=0 same inputs -> pc unchanged.
REQ-044 pc=0x0100, jump_taken+jump_link, imm=0x010 -> pc=0x0122, top=0x0102; return_cmd -> pc=0x0102, count 0.
REQ-045 5 JL with DEPTH=4 -> overflow=1, count=4; 5 returns -> 5th gives pc=seq, underflow=1.
REQ-046 int_enable, halt_cmd at pc=0x0040 -> halted=1; int_req -> pc=0x0010, int_active=1, int_en=0; return_cmd -> pc=0x0042, int_en=1.
REQ-047 pc=0xFFFE sequential -> pc=0x0000; reset during handler -> all outputs at reset values.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// reset-time constants and the stack occupancy width helper.
package pc_seq_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_t;

    localparam logic [15:0] INT_VECTOR_DEFAULT = 16'h0010;
    localparam int unsigned INSN_BYTES         = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack; pushes when full and pops when empty are ignored
// here, with the error reporting left to the caller.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   push_data,
    output logic [W-1:0]                   top,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned CW = count_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = count[AW-1:0];
    assign top_idx = AW'(count - CW'(1));
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Contents need no reset; only the occupancy count is architectural.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with branch/jump/call/return, halt, and a single
// level of interrupt entry using the shared return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned BR_IMM_W    = 6,
    parameter int unsigned J_IMM_W     = 12,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [15:0] INT_VECTOR  = INT_VECTOR_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clk_en,
    input  logic                                  branch_taken,
    input  logic [BR_IMM_W-1:0]                   branch_immediate,
    input  logic                                  jump_taken,
    input  logic                                  jump_link,
    input  logic [J_IMM_W-1:0]                    jump_immediate,
    input  logic                                  return_cmd,
    input  logic                                  halt_cmd,
    input  logic                                  int_enable_cmd,
    input  logic                                  int_disable_cmd,
    input  logic                                  int_req,
    output logic [PC_W-1:0]                       pc,
    output logic                                  halted,
    output logic                                  int_active,
    output logic                                  int_en,
    output logic [count_width(STACK_DEPTH)-1:0]   stack_count,
    output logic                                  stack_overflow,
    output logic                                  stack_underflow
);

    localparam logic [PC_W-1:0] INT_PC = PC_W'(INT_VECTOR);

    seq_state_t      state, state_n;
    logic [PC_W-1:0] pc_n;
    logic            int_en_n, int_active_n;
    logic            ovf_n, unf_n;

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] br_sext, j_sext;
    logic [PC_W-1:0] br_target, j_target;
    logic            irq;

    logic            push, pop;
    logic [PC_W-1:0] top;
    logic            full, empty;

    assign seq       = pc + PC_W'(INSN_BYTES);
    assign br_sext   = PC_W'($signed(branch_immediate));
    assign j_sext    = PC_W'($signed(jump_immediate));
    assign br_target = seq + {br_sext[PC_W-2:0], 1'b0};
    assign j_target  = seq + {j_sext[PC_W-2:0], 1'b0};
    assign irq       = int_req & int_en & ~int_active;
    assign halted    = (state == ST_HALTED);

    pc_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .top       (top),
        .count     (stack_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RUN;
            pc              <= '0;
            int_en          <= 1'b0;
            int_active      <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            int_en          <= int_en_n;
            int_active      <= int_active_n;
            stack_overflow  <= ovf_n;
            stack_underflow <= unf_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        int_en_n     = int_en;
        int_active_n = int_active;
        ovf_n        = stack_overflow;
        unf_n        = stack_underflow;
        push         = 1'b0;
        pop          = 1'b0;

        if (clk_en) begin
            if (irq) begin
                // Entry from HALTED pushes pc+2 too, which equals seq.
                push         = 1'b1;
                pc_n         = INT_PC;
                int_active_n = 1'b1;
                int_en_n     = 1'b0;
                state_n      = ST_RUN;
            end else if (state == ST_RUN) begin
                if (return_cmd) begin
                    if (empty) begin
                        pc_n  = seq;
                        unf_n = 1'b1;
                    end else begin
                        pc_n = top;
                        pop  = 1'b1;
                        if (int_active) begin
                            int_active_n = 1'b0;
                            int_en_n     = 1'b1;
                        end
                    end
                end else if (jump_taken) begin
                    pc_n = j_target;
                    push = jump_link;
                end else if (branch_taken) begin
                    pc_n = br_target;
                end else if (halt_cmd) begin
                    state_n = ST_HALTED;
                end else begin
                    pc_n = seq;
                end

                // Explicit enable/disable commands take precedence over the
                // enable restored by a handler return in the same cycle.
                if (int_disable_cmd) begin
                    int_en_n = 1'b0;
                end else if (int_enable_cmd) begin
                    int_en_n = 1'b1;
                end
            end

            if (push && full) begin
                ovf_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based
// behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int DEPTH = 4;
    localparam int INTV  = 'h0010;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        branch_taken;
    logic [5:0]  branch_immediate;
    logic        jump_taken;
    logic        jump_link;
    logic [11:0] jump_immediate;
    logic        return_cmd;
    logic        halt_cmd;
    logic        int_enable_cmd;
    logic        int_disable_cmd;
    logic        int_req;
    logic [15:0] pc;
    logic        halted;
    logic        int_active;
    logic        int_en;
    logic [2:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    int checks = 0;
    int errors = 0;

    int m_pc;
    bit m_halt, m_ien, m_iact, m_ovf, m_unf;
    int stk[$];

    pc_sequencer #(
        .PC_W        (16),
        .BR_IMM_W    (6),
        .J_IMM_W     (12),
        .STACK_DEPTH (DEPTH),
        .INT_VECTOR  (16'h0010)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .branch_taken     (branch_taken),
        .branch_immediate (branch_immediate),
        .jump_taken       (jump_taken),
        .jump_link        (jump_link),
        .jump_immediate   (jump_immediate),
        .return_cmd       (return_cmd),
        .halt_cmd         (halt_cmd),
        .int_enable_cmd   (int_enable_cmd),
        .int_disable_cmd  (int_disable_cmd),
        .int_req          (int_req),
        .pc               (pc),
        .halted           (halted),
        .int_active       (int_active),
        .int_en           (int_en),
        .stack_count      (stack_count),
        .stack_overflow   (stack_overflow),
        .stack_underflow  (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input int v);
        if (stk.size() == DEPTH) m_ovf = 1;
        else stk.push_back(v);
    endtask

    task automatic model_step();
        int seqv;
        seqv = (m_pc + 2) & 'hFFFF;
        if (reset) begin
            m_pc = 0; m_halt = 0; m_ien = 0; m_iact = 0; m_ovf = 0; m_unf = 0;
            stk.delete();
        end else if (clk_en) begin
            if (int_req && m_ien && !m_iact) begin
                m_push(seqv);
                m_pc = INTV; m_iact = 1; m_ien = 0; m_halt = 0;
            end else if (!m_halt) begin
                if (return_cmd) begin
                    if (stk.size() == 0) begin
                        m_pc = seqv; m_unf = 1;
                    end else begin
                        m_pc = stk.pop_back();
                        if (m_iact) begin m_iact = 0; m_ien = 1; end
                    end
                end else if (jump_taken) begin
                    if (jump_link) m_push(seqv);
                    m_pc = (seqv + 2 * int'($signed(jump_immediate))) & 'hFFFF;
                end else if (branch_taken) begin
                    m_pc = (seqv + 2 * int'($signed(branch_immediate))) & 'hFFFF;
                end else if (halt_cmd) begin
                    m_halt = 1;
                end else begin
                    m_pc = seqv;
                end
                if (int_disable_cmd) m_ien = 0;
                else if (int_enable_cmd) m_ien = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("halted", halted, m_halt);
        check("int_active", int_active, m_iact);
        check("int_en", int_en, m_ien);
        check("stack_count", stack_count, stk.size());
        check("overflow", stack_overflow, m_ovf);
        check("underflow", stack_underflow, m_unf);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 0; clk_en = 1; branch_taken = 0; branch_immediate = '0;
        jump_taken = 0; jump_link = 0; jump_immediate = '0; return_cmd = 0;
        halt_cmd = 0; int_enable_cmd = 0; int_disable_cmd = 0; int_req = 0;
    endtask

    task automatic goto_pc(input int target);
        int diff;
        idle();
        diff = (target - ((m_pc + 2) & 'hFFFF)) & 'hFFFF;
        if (diff >= 32768) diff -= 65536;
        jump_taken = 1;
        jump_immediate = 12'(diff / 2);
        step();
        idle();
    endtask

    initial begin
        idle();
        m_pc = 0;
        reset = 1;
        step();
        check("rst_pc", pc, 0);
        check("rst_count", stack_count, 0);

        idle();
        step(); check("seq_pc1", pc, 'h0002);
        step(); check("seq_pc2", pc, 'h0004);
        step(); check("seq_pc3", pc, 'h0006);

        goto_pc('h0010);
        check("goto_10", pc, 'h0010);
        branch_taken = 1; branch_immediate = 6'b111110;
        step(); check("branch_back", pc, 'h000E);
        clk_en = 0;
        step(); check("clk_en_hold", pc, 'h000E);

        goto_pc('h0100);
        jump_taken = 1; jump_link = 1; jump_immediate = 12'h010;
        step(); check("jl_pc", pc, 'h0122); check("jl_count", stack_count, 1);
        idle(); return_cmd = 1;
        step(); check("ret_pc", pc, 'h0102); check("ret_count", stack_count, 0);

        idle(); jump_taken = 1; jump_link = 1;
        for (int i = 0; i < 5; i++) step();
        check("ovf_flag", stack_overflow, 1);
        check("ovf_count", stack_count, 4);
        check("ovf_pc", pc, 'h010C);
        idle(); return_cmd = 1;
        for (int i = 0; i < 4; i++) step();
        check("pop4_pc", pc, 'h0104);
        check("unf_before", stack_underflow, 0);
        step();
        check("unf_pc", pc, 'h0106);
        check("unf_flag", stack_underflow, 1);

        idle(); reset = 1; step();
        idle(); int_enable_cmd = 1; step();
        check("ien_set", int_en, 1);
        goto_pc('h0040);
        halt_cmd = 1; step();
        check("halt_flag", halted, 1); check("halt_pc", pc, 'h0040);
        idle(); jump_taken = 1; jump_immediate = 12'h005; step();
        check("halt_ignores_jump", pc, 'h0040);
        idle(); int_req = 1; step();
        check("irq_pc", pc, 'h0010); check("irq_active", int_active, 1);
        check("irq_ien", int_en, 0); check("irq_run", halted, 0);
        idle(); return_cmd = 1; step();
        check("iret_pc", pc, 'h0042); check("iret_ien", int_en, 1);
        check("iret_active", int_active, 0);

        goto_pc('hFFFE);
        check("goto_fffe", pc, 'hFFFE);
        step(); check("wrap_pc", pc, 'h0000);
        int_req = 1; step();
        check("handler_entry", int_active, 1);
        reset = 1; return_cmd = 1; jump_taken = 1; step();
        check("mid_rst_pc", pc, 0); check("mid_rst_active", int_active, 0);
        check("mid_rst_ien", int_en, 0); check("mid_rst_count", stack_count, 0);

        for (int i = 0; i < 500; i++) begin
            reset            = ($urandom_range(0, 63) == 0);
            clk_en           = ($urandom_range(0, 7) != 0);
            branch_taken     = ($urandom_range(0, 3) == 0);
            branch_immediate = 6'($urandom);
            jump_taken       = ($urandom_range(0, 4) == 0);
            jump_link        = ($urandom_range(0, 1) == 0);
            jump_immediate   = 12'($urandom);
            return_cmd       = ($urandom_range(0, 4) == 0);
            halt_cmd         = ($urandom_range(0, 11) == 0);
            int_enable_cmd   = ($urandom_range(0, 5) == 0);
            int_disable_cmd  = ($urandom_range(0, 9) == 0);
            int_req          = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
